// File: rtl/riscv_dmem_arbiter_pkg.sv
// Shared configuration for the data-memory arbiter: default widths, owner
// encodings and the response-register record.
package riscv_dmem_arbiter_pkg;

  localparam int DEFAULT_XLEN          = 32;
  localparam int DEFAULT_DMEM_ADDR_BIT = 12;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_X = 1'b1
  } owner_e;

  // One in-flight access: who issued it, whether it was a read, and whether
  // it was suppressed for being out of range.
  typedef struct packed {
    owner_e owner;
    logic   rd;
    logic   err;
  } rsp_t;

  localparam rsp_t RSP_IDLE = '{owner: OWN_C, rd: 1'b0, err: 1'b0};

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/riscv_dmem_rsp_reg.sv
// Response register: remembers the owner and kind of the access granted this
// cycle so its read data can be steered when dmem returns it next cycle.
module riscv_dmem_rsp_reg
  import riscv_dmem_arbiter_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  rsp_t i_rsp,
  output rsp_t o_rsp
);

  rsp_t rsp_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_q <= RSP_IDLE;
    end else begin
      rsp_q <= i_rsp;
    end
  end

  assign o_rsp = rsp_q;

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous-read dmem: core
// port C has priority, debug port X wins once it has waited STARVE_MAX cycles.
module riscv_dmem_arbiter
  import riscv_dmem_arbiter_pkg::*;
#(
  parameter int XLEN          = DEFAULT_XLEN,
  parameter int DMEM_ADDR_BIT = DEFAULT_DMEM_ADDR_BIT,
  parameter int STARVE_MAX    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_c_req,
  input  logic                     i_c_wen,
  input  logic [XLEN-1:0]          i_c_addr,
  input  logic [XLEN-1:0]          i_c_wr_data,
  input  logic [3:0]               i_c_byte_sel,
  output logic                     o_c_gnt,
  output logic                     o_c_rvalid,
  output logic                     o_c_err,
  output logic [XLEN-1:0]          o_c_rd_data,
  output logic                     o_stall_core,
  input  logic                     i_x_req,
  input  logic                     i_x_wen,
  input  logic [XLEN-1:0]          i_x_addr,
  input  logic [XLEN-1:0]          i_x_wr_data,
  input  logic [3:0]               i_x_byte_sel,
  output logic                     o_x_gnt,
  output logic                     o_x_rvalid,
  output logic                     o_x_err,
  output logic [XLEN-1:0]          o_x_rd_data,
  output logic [DMEM_ADDR_BIT-3:0] o_dmem_addr,
  output logic                     o_dmem_wr_en,
  output logic [XLEN-1:0]          o_dmem_wr_data,
  output logic [3:0]               o_dmem_byte_sel,
  input  logic [XLEN-1:0]          i_dmem_rd_data
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]      starve_cnt_q, starve_cnt_d;
  logic            x_win;
  logic            any_gnt;
  logic            sel_wen;
  logic [XLEN-1:0] sel_addr;
  logic [XLEN-1:0] sel_wr_data;
  logic [3:0]      sel_byte_sel;
  logic            out_of_range;
  rsp_t            rsp_d, rsp_q;
  logic            rsp_valid;
  logic            rsp_is_c, rsp_is_x;

  // Handshake: a requester holds req and payload stable until it samples
  // gnt = 1 in the same cycle; gnt is the only acceptance point, nothing is
  // buffered. Grants are held low while reset is asserted.
  assign x_win        = i_x_req & (~i_c_req | (starve_cnt_q >= STARVE_LIM));
  assign o_x_gnt      = x_win & ~i_rst;
  assign o_c_gnt      = i_c_req & ~x_win & ~i_rst;
  assign o_stall_core = i_c_req & ~o_c_gnt;
  assign any_gnt      = o_c_gnt | o_x_gnt;

  assign starve_cnt_d = (i_x_req & ~o_x_gnt) ? sat_inc4(starve_cnt_q) : 4'd0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    sel_wen      = i_c_wen;
    sel_addr     = i_c_addr;
    sel_wr_data  = i_c_wr_data;
    sel_byte_sel = i_c_byte_sel;
    if (o_x_gnt) begin
      sel_wen      = i_x_wen;
      sel_addr     = i_x_addr;
      sel_wr_data  = i_x_wr_data;
      sel_byte_sel = i_x_byte_sel;
    end
  end

  // Beyond the implemented dmem, or a full-word access that is not aligned.
  assign out_of_range = (|sel_addr[XLEN-1:DMEM_ADDR_BIT]) |
                        ((|sel_addr[1:0]) & (sel_byte_sel == 4'b1111));

  assign o_dmem_addr     = any_gnt ? sel_addr[DMEM_ADDR_BIT-1:2] : '0;
  assign o_dmem_wr_en    = any_gnt & sel_wen & ~out_of_range;
  assign o_dmem_wr_data  = any_gnt ? sel_wr_data : '0;
  assign o_dmem_byte_sel = any_gnt ? sel_byte_sel : 4'b0000;

  always_comb begin
    rsp_d       = RSP_IDLE;
    rsp_d.owner = o_x_gnt ? OWN_X : OWN_C;
    rsp_d.rd    = any_gnt & ~sel_wen;
    rsp_d.err   = any_gnt & out_of_range;
  end

  riscv_dmem_rsp_reg u_rsp_reg (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_rsp (rsp_d),
    .o_rsp (rsp_q)
  );

  assign rsp_valid = rsp_q.rd & ~rsp_q.err;
  assign rsp_is_c  = (rsp_q.owner == OWN_C);
  assign rsp_is_x  = (rsp_q.owner == OWN_X);

  // Read data is zeroed unless it is a valid read response for that port,
  // which also hides whatever dmem returns for a suppressed access.
  assign o_c_rvalid  = rsp_is_c & rsp_valid;
  assign o_c_err     = rsp_is_c & rsp_q.err;
  assign o_c_rd_data = o_c_rvalid ? i_dmem_rd_data : '0;
  assign o_x_rvalid  = rsp_is_x & rsp_valid;
  assign o_x_err     = rsp_is_x & rsp_q.err;
  assign o_x_rd_data = o_x_rvalid ? i_dmem_rd_data : '0;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Directed bench for riscv_dmem_arbiter with a small byte-enabled dmem model.
module tb_riscv_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req, c_wen, x_req, x_wen;
  logic [31:0] c_addr, c_wr_data, x_addr, x_wr_data;
  logic [3:0]  c_byte_sel, x_byte_sel;
  logic        c_gnt, c_rvalid, c_err, stall_core;
  logic        x_gnt, x_rvalid, x_err;
  logic [31:0] c_rd_data, x_rd_data;
  logic [9:0]  dmem_addr;
  logic        dmem_wr_en;
  logic [31:0] dmem_wr_data, dmem_rd_data;
  logic [3:0]  dmem_byte_sel;
  logic [31:0] mem [0:1023];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_dmem_arbiter #(.XLEN(32), .DMEM_ADDR_BIT(12), .STARVE_MAX(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_c_req(c_req), .i_c_wen(c_wen), .i_c_addr(c_addr),
    .i_c_wr_data(c_wr_data), .i_c_byte_sel(c_byte_sel),
    .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_err(c_err),
    .o_c_rd_data(c_rd_data), .o_stall_core(stall_core),
    .i_x_req(x_req), .i_x_wen(x_wen), .i_x_addr(x_addr),
    .i_x_wr_data(x_wr_data), .i_x_byte_sel(x_byte_sel),
    .o_x_gnt(x_gnt), .o_x_rvalid(x_rvalid), .o_x_err(x_err),
    .o_x_rd_data(x_rd_data),
    .o_dmem_addr(dmem_addr), .o_dmem_wr_en(dmem_wr_en),
    .o_dmem_wr_data(dmem_wr_data), .o_dmem_byte_sel(dmem_byte_sel),
    .i_dmem_rd_data(dmem_rd_data)
  );

  // dmem model: preloaded with 0xA000_0000 | word index while reset is high.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 | 32'(i);
    end else if (dmem_wr_en) begin
      if (dmem_byte_sel[0]) mem[dmem_addr][7:0]   <= dmem_wr_data[7:0];
      if (dmem_byte_sel[1]) mem[dmem_addr][15:8]  <= dmem_wr_data[15:8];
      if (dmem_byte_sel[2]) mem[dmem_addr][23:16] <= dmem_wr_data[23:16];
      if (dmem_byte_sel[3]) mem[dmem_addr][31:24] <= dmem_wr_data[31:24];
    end
    dmem_rd_data <= mem[dmem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_c(input logic req, input logic wen, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] bs);
    c_req = req; c_wen = wen; c_addr = addr; c_wr_data = data; c_byte_sel = bs;
  endtask

  task automatic drive_x(input logic req, input logic wen, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] bs);
    x_req = req; x_wen = wen; x_addr = addr; x_wr_data = data; x_byte_sel = bs;
  endtask

  task automatic idle_all();
    drive_c(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_x(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: requests present, nothing granted, stall follows c_req.
    drive_c(1'b1, 1'b1, 32'h10, 32'h1111_1111, 4'hF);
    drive_x(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    tick(); #1;
    check("rst_c_gnt", c_gnt, 0);
    check("rst_x_gnt", x_gnt, 0);
    check("rst_wr_en", dmem_wr_en, 0);
    check("rst_stall", stall_core, 1);
    check("rst_c_rvalid", c_rvalid, 0);
    check("rst_x_rvalid", x_rvalid, 0);
    check("rst_c_err", c_err, 0);
    check("rst_c_rd_data", c_rd_data, 0);
    check("rst_x_rd_data", x_rd_data, 0);
    check("rst_starve", dut.starve_cnt_q, 0);
    tick();
    rst = 1'b0;
    idle_all();
    #1;
    check("post_rst_c_rvalid", c_rvalid, 0);

    // Core-only write then read of 0x10.
    tick();
    drive_c(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF); #1;
    check("t1_wr_gnt", c_gnt, 1);
    check("t1_wr_stall", stall_core, 0);
    check("t1_wr_en", dmem_wr_en, 1);
    check("t1_wr_addr", dmem_addr, 32'h4);
    check("t1_wr_data", dmem_wr_data, 32'hDEAD_BEEF);
    tick();
    drive_c(1'b1, 1'b0, 32'h10, 32'h0, 4'hF); #1;
    check("t1_rd_gnt", c_gnt, 1);
    check("t1_rd_stall", stall_core, 0);
    check("t1_rd_wr_en", dmem_wr_en, 0);
    check("t1_wr_no_rvalid", c_rvalid, 0);
    tick();
    idle_all(); #1;
    check("t1_rvalid", c_rvalid, 1);
    check("t1_rd_data", c_rd_data, 32'hDEAD_BEEF);
    check("t1_x_rd_data", x_rd_data, 0);
    check("t1_stall_idle", stall_core, 0);

    // Contention: C reads every cycle, X reads 0x20 from cycle 0.
    tick();
    drive_c(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    drive_x(1'b1, 1'b0, 32'h20, 32'h0, 4'hF); #1;
    check("t2_c0_stall", stall_core, 0);
    check("t2_c0_x_gnt", x_gnt, 0);
    check("t2_c0_starve", dut.starve_cnt_q, 0);
    for (int k = 1; k <= 3; k++) begin
      tick(); #1;
      check($sformatf("t2_c%0d_stall", k), stall_core, 0);
      check($sformatf("t2_c%0d_x_gnt", k), x_gnt, 0);
      check($sformatf("t2_c%0d_starve", k), dut.starve_cnt_q, 32'(k));
      check($sformatf("t2_c%0d_c_rvalid", k), c_rvalid, 1);
    end
    tick(); #1;
    check("t2_c4_x_gnt", x_gnt, 1);
    check("t2_c4_c_gnt", c_gnt, 0);
    check("t2_c4_stall", stall_core, 1);
    check("t2_c4_starve", dut.starve_cnt_q, 4);
    check("t2_c4_addr", dmem_addr, 32'h8);
    tick();
    drive_x(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
    check("t2_c5_x_rvalid", x_rvalid, 1);
    check("t2_c5_x_rd_data", x_rd_data, 32'hA000_0008);
    check("t2_c5_c_rvalid", c_rvalid, 0);
    check("t2_c5_c_rd_data", c_rd_data, 0);
    check("t2_c5_stall", stall_core, 0);
    check("t2_c5_starve", dut.starve_cnt_q, 0);
    tick();
    idle_all();

    // X-only write, then C reads it back.
    tick();
    drive_x(1'b1, 1'b1, 32'h40, 32'h1234_5678, 4'hF); #1;
    check("t3_x_gnt", x_gnt, 1);
    check("t3_c_gnt", c_gnt, 0);
    check("t3_wr_en", dmem_wr_en, 1);
    check("t3_addr", dmem_addr, 32'h10);
    tick();
    drive_x(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_c(1'b1, 1'b0, 32'h40, 32'h0, 4'hF); #1;
    check("t3_c_gnt_rd", c_gnt, 1);
    check("t3_x_wr_no_rvalid", x_rvalid, 0);
    tick();
    idle_all(); #1;
    check("t3_c_rvalid", c_rvalid, 1);
    check("t3_c_rd_data", c_rd_data, 32'h1234_5678);
    check("t3_x_rvalid", x_rvalid, 0);

    // Out-of-range C write must not alias onto word 0.
    tick();
    drive_c(1'b1, 1'b1, 32'h0001_0000, 32'hBAD0_BAD0, 4'hF); #1;
    check("t4_oor_gnt", c_gnt, 1);
    check("t4_oor_wr_en", dmem_wr_en, 0);
    tick();
    drive_c(1'b1, 1'b0, 32'h0, 32'h0, 4'hF); #1;
    check("t4_oor_c_err", c_err, 1);
    check("t4_oor_c_rvalid", c_rvalid, 0);
    check("t4_oor_x_err", x_err, 0);
    tick();
    idle_all(); #1;
    check("t4_alias_rvalid", c_rvalid, 1);
    check("t4_alias_data", c_rd_data, 32'hA000_0000);
    check("t4_alias_err", c_err, 0);
    // Misaligned full-word X read.
    tick();
    drive_x(1'b1, 1'b0, 32'h42, 32'h0, 4'hF); #1;
    check("t4_mis_x_gnt", x_gnt, 1);
    tick();
    idle_all(); #1;
    check("t4_mis_x_err", x_err, 1);
    check("t4_mis_x_rvalid", x_rvalid, 0);
    check("t4_mis_x_rd_data", x_rd_data, 0);
    check("t4_mis_c_err", c_err, 0);

    // Back-to-back alternating owners.
    tick();
    drive_c(1'b1, 1'b0, 32'h10, 32'h0, 4'hF); #1;
    check("t6_a_c_gnt", c_gnt, 1);
    tick();
    drive_c(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_x(1'b1, 1'b0, 32'h14, 32'h0, 4'hF); #1;
    check("t6_b_x_gnt", x_gnt, 1);
    check("t6_b_c_rvalid", c_rvalid, 1);
    check("t6_b_c_rd_data", c_rd_data, 32'hDEAD_BEEF);
    check("t6_b_x_rvalid", x_rvalid, 0);
    check("t6_b_x_rd_data", x_rd_data, 0);
    tick();
    drive_x(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_c(1'b1, 1'b0, 32'h18, 32'h0, 4'hF); #1;
    check("t6_c_c_gnt", c_gnt, 1);
    check("t6_c_x_rvalid", x_rvalid, 1);
    check("t6_c_x_rd_data", x_rd_data, 32'hA000_0005);
    check("t6_c_c_rvalid", c_rvalid, 0);
    check("t6_c_c_rd_data", c_rd_data, 0);
    tick();
    idle_all(); #1;
    check("t6_d_c_rvalid", c_rvalid, 1);
    check("t6_d_c_rd_data", c_rd_data, 32'hA000_0006);
    check("t6_d_x_rd_data", x_rd_data, 0);

    // Reset asserted between a C read grant and its response edge.
    tick();
    drive_c(1'b1, 1'b0, 32'h10, 32'h0, 4'hF); #1;
    check("t5_c_gnt", c_gnt, 1);
    #2;
    rst = 1'b1;
    drive_c(1'b1, 1'b1, 32'h10, 32'h5555_5555, 4'hF);
    drive_x(1'b1, 1'b0, 32'h20, 32'h0, 4'hF); #1;
    check("t5_rst_c_gnt", c_gnt, 0);
    check("t5_rst_x_gnt", x_gnt, 0);
    check("t5_rst_wr_en", dmem_wr_en, 0);
    check("t5_rst_stall", stall_core, 1);
    check("t5_rst_c_rvalid", c_rvalid, 0);
    tick();
    check("t5_rst_edge_c_rvalid", c_rvalid, 0);
    check("t5_rst_edge_x_rvalid", x_rvalid, 0);
    tick();
    rst = 1'b0;
    idle_all(); #1;
    check("t5_post_c_rvalid", c_rvalid, 0);
    check("t5_post_c_rd_data", c_rd_data, 0);
    check("t5_post_stall", stall_core, 0);
    tick(); #1;
    check("t5_post2_c_rvalid", c_rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
